// File: rtl/audio_pwm_arbiter.sv
// N-channel PCM-to-PWM output stage with per-period source arbitration and a periodic tick.
// Optional MIX_EN build: saturating mix of all enabled channels instead of priority select.
module audio_pwm_arbiter #(
    parameter int N_CH     = 2,
    parameter int SAMPLE_W = 8,
    parameter int TICK_DIV = 10000,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       sysreset,
    input  logic [N_CH-1:0]            ch_en,
    input  logic [N_CH-1:0]            ch_valid,
    input  logic [N_CH*SAMPLE_W-1:0]   ch_data,
    output logic [N_CH-1:0]            ch_ready,
    input  logic                       mute,
    output logic                       aud_pwm,
    output logic                       aud_sd,
    output logic [CH_W-1:0]            active_ch,
    output logic                       underrun,
    output logic                       tick
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SAMPLE_W-1:0] MIDSCALE  = SAMPLE_W'(1) << (SAMPLE_W - 1);

    logic [SAMPLE_W-1:0] pwm_cnt;
    logic [SAMPLE_W-1:0] duty;
    logic [TICK_W-1:0]   tick_cnt;

    logic                boundary;
    logic [CH_W-1:0]     sel;
    logic                none_en;
    logic [SAMPLE_W-1:0] sample [N_CH];

    logic [SAMPLE_W-1:0] duty_nxt;
    logic                sd_nxt;
    logic [CH_W-1:0]     act_nxt;
    logic                und_nxt;

    assign boundary = (pwm_cnt == '1);

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            sample[i] = ch_data[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Lowest enabled index wins; none_en flags an all-idle request vector.
    always_comb begin
        sel     = '0;
        none_en = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (none_en && ch_en[i]) begin
                sel     = CH_W'(i);
                none_en = 1'b0;
            end
        end
    end

`ifdef MIX_EN
    localparam int SUM_W = SAMPLE_W + $clog2(N_CH);
    localparam logic [SUM_W-1:0] FULL = SUM_W'((1 << SAMPLE_W) - 1);

    logic [SUM_W-1:0]    mix_sum;
    logic [SAMPLE_W-1:0] mix_sat;
    logic                any_valid;
    logic                any_missing;

    always_comb begin
        mix_sum     = '0;
        any_valid   = 1'b0;
        any_missing = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_en[i]) begin
                if (ch_valid[i]) begin
                    mix_sum   = mix_sum + SUM_W'(sample[i]);
                    any_valid = 1'b1;
                end else begin
                    any_missing = 1'b1;
                end
            end
        end
        mix_sat = (mix_sum > FULL) ? '1 : mix_sum[SAMPLE_W-1:0];
    end

    always_comb begin
        duty_nxt = duty;
        sd_nxt   = aud_sd;
        act_nxt  = active_ch;
        und_nxt  = 1'b0;
        ch_ready = '0;
        if (boundary) begin
            ch_ready = ch_en;
            if (none_en) begin
                duty_nxt = '0;
                sd_nxt   = 1'b0;
            end else if (mute) begin
                duty_nxt = '0;
                sd_nxt   = 1'b0;
                act_nxt  = sel;
            end else begin
                duty_nxt = any_valid ? mix_sat : MIDSCALE;
                sd_nxt   = 1'b1;
                act_nxt  = sel;
                und_nxt  = any_missing;
            end
        end
    end
`else
    always_comb begin
        duty_nxt = duty;
        sd_nxt   = aud_sd;
        act_nxt  = active_ch;
        und_nxt  = 1'b0;
        ch_ready = '0;
        if (boundary && !none_en) begin
            ch_ready[sel] = 1'b1;
            act_nxt       = sel;
            if (mute) begin
                // Handshake still completes so the muted sample is consumed.
                duty_nxt = '0;
                sd_nxt   = 1'b0;
            end else if (ch_valid[sel]) begin
                duty_nxt = sample[sel];
                sd_nxt   = 1'b1;
            end else begin
                duty_nxt = MIDSCALE;
                sd_nxt   = 1'b1;
                und_nxt  = 1'b1;
            end
        end else if (boundary) begin
            duty_nxt = '0;
            sd_nxt   = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge sysreset) begin
        if (!sysreset) begin
            pwm_cnt   <= '0;
            duty      <= '0;
            aud_pwm   <= 1'b0;
            aud_sd    <= 1'b0;
            active_ch <= '0;
            underrun  <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            duty      <= duty_nxt;
            aud_sd    <= sd_nxt;
            active_ch <= act_nxt;
            underrun  <= und_nxt;
            aud_pwm   <= (pwm_cnt < duty);
        end
    end

    always_ff @(posedge clk or negedge sysreset) begin
        if (!sysreset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == TICK_LAST);
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_pwm_arbiter.sv
// Directed bench for audio_pwm_arbiter (N_CH=2, SAMPLE_W=8, TICK_DIV=10); MIX_EN selects mix checks.
module tb_audio_pwm_arbiter;

    logic        clk;
    logic        sysreset;
    logic [1:0]  ch_en;
    logic [1:0]  ch_valid;
    logic [15:0] ch_data;
    logic [1:0]  ch_ready;
    logic        mute;
    logic        aud_pwm;
    logic        aud_sd;
    logic [0:0]  active_ch;
    logic        underrun;
    logic        tick;

    int errors = 0;
    int checks = 0;

    // Reference period counter: the boundary is the cycle where this reads 255.
    logic [7:0] m_cnt;

    audio_pwm_arbiter #(.N_CH(2), .SAMPLE_W(8), .TICK_DIV(10)) dut (
        .clk(clk), .sysreset(sysreset), .ch_en(ch_en), .ch_valid(ch_valid),
        .ch_data(ch_data), .ch_ready(ch_ready), .mute(mute), .aud_pwm(aud_pwm),
        .aud_sd(aud_sd), .active_ch(active_ch), .underrun(underrun), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge sysreset) begin
        if (!sysreset) m_cnt <= 8'd0;
        else           m_cnt <= m_cnt + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pwm"}, 32'(aud_pwm), 0);
        chk({tag, "_sd"}, 32'(aud_sd), 0);
        chk({tag, "_act"}, 32'(active_ch), 0);
        chk({tag, "_und"}, 32'(underrun), 0);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_rdy"}, 32'(ch_ready), 0);
    endtask

    task automatic wait_boundary(input string tag);
        for (int n = 0; n < 300 && m_cnt != 8'hFF; n++) @(negedge clk);
        chk({tag, "_bnd"}, 32'(m_cnt), 255);
    endtask

    // Runs one full period starting at a boundary and checks the period's totals.
    task automatic measure(input string tag, input int exp_high, input int exp_r0,
                           input int exp_r1, input int exp_und, input int exp_sd,
                           input int exp_act);
        int high = 0;
        int r0 = 0;
        int r1 = 0;
        int und = 0;
        wait_boundary(tag);
        for (int j = 0; j < 256; j++) begin
            @(posedge clk);
            @(negedge clk);
            high += int'(aud_pwm);
            r0   += int'(ch_ready[0]);
            r1   += int'(ch_ready[1]);
            und  += int'(underrun);
        end
        chk({tag, "_high"}, 32'(high), 32'(exp_high));
        chk({tag, "_rdy0"}, 32'(r0), 32'(exp_r0));
        chk({tag, "_rdy1"}, 32'(r1), 32'(exp_r1));
        chk({tag, "_und"}, 32'(und), 32'(exp_und));
        chk({tag, "_sd"}, 32'(aud_sd), 32'(exp_sd));
        chk({tag, "_act"}, 32'(active_ch), 32'(exp_act));
    endtask

    initial begin
        sysreset = 1'b0;
        ch_en    = 2'b00;
        ch_valid = 2'b00;
        ch_data  = 16'h0000;
        mute     = 1'b0;

        // Reset held while inputs toggle
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ch_en    = ~ch_en;
            ch_valid = ~ch_valid;
            ch_data  = ~ch_data;
            mute     = ~mute;
            #1;
            check_all_zero("rst_hold");
        end
        ch_en = 2'b00; ch_valid = 2'b00; ch_data = 16'h0000; mute = 1'b0;

        // Tick: first pulse 10 cycles after release, then every 10
        @(negedge clk);
        sysreset = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            chk($sformatf("tick_c%0d", k), 32'(tick), (k % 10 == 0) ? 32'd1 : 32'd0);
        end

        // Single channel, data 64
        ch_en = 2'b01; ch_valid = 2'b11; ch_data = {8'd0, 8'd64};
        measure("single", 64, 1, 0, 0, 1, 0);

`ifdef MIX_EN
        ch_en = 2'b11; ch_valid = 2'b11; ch_data = {8'd100, 8'd200};
        measure("mix_sat", 255, 1, 1, 0, 1, 0);
        ch_data = {8'd60, 8'd50};
        measure("mix_sum", 110, 1, 1, 0, 1, 0);
        ch_valid = 2'b01;
        measure("mix_part", 50, 1, 1, 1, 1, 0);
`else
        ch_en = 2'b11; ch_valid = 2'b11; ch_data = {8'd200, 8'd32};
        measure("prio", 32, 1, 0, 0, 1, 0);
        // Drop ch0 mid-period: nothing changes until the next boundary
        repeat (100) @(negedge clk);
        ch_en = 2'b10;
        @(negedge clk);
        chk("drop_hold_act", 32'(active_ch), 0);
        chk("drop_hold_rdy", 32'(ch_ready), 0);
        measure("drop", 200, 0, 1, 0, 1, 1);
`endif

        // Reset mid-period clears state immediately
        repeat (60) @(negedge clk);
        sysreset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (3) @(negedge clk);
        chk("rst_mid_rdy_held", 32'(ch_ready), 0);
        sysreset = 1'b1;

        // All channels disabled
        ch_en = 2'b00; ch_valid = 2'b11; ch_data = {8'd90, 8'd90};
        measure("disable", 0, 0, 0, 0, 0, 0);

        // Underrun: midscale
        ch_en = 2'b01; ch_valid = 2'b00;
        measure("underrun", 128, 1, 0, 1, 1, 0);

        // Mute: silence but samples still consumed
        ch_valid = 2'b11; ch_data = {8'd0, 8'd64}; mute = 1'b1;
        measure("mute", 0, 1, 0, 0, 0, 0);

        mute = 1'b0; ch_data = {8'd0, 8'd255};
        measure("full", 255, 1, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
